// File: rtl/echo_medidor_if.sv
// Sensor handshake and SD distance-code bus of the ultrasonic ranger front end.
interface echo_medidor_if;
    logic enable;
    logic echo;
    logic trig;
    logic busy;
    logic valid;
    logic SD1;
    logic SD2;
    logic SD3;
    logic SD4;
    logic SD5;

    // Ranger side: consumes enable/echo, produces trigger, status and distance code
    modport master (
        input  enable,
        input  echo,
        output trig,
        output busy,
        output valid,
        output SD1,
        output SD2,
        output SD3,
        output SD4,
        output SD5
    );

    // Controller/sensor/display side
    modport slave (
        output enable,
        output echo,
        input  trig,
        input  busy,
        input  valid,
        input  SD1,
        input  SD2,
        input  SD3,
        input  SD4,
        input  SD5
    );
endinterface

// File: rtl/echo_medidor.sv
// Ultrasonic ranger front end: fires the trigger, times the echo pulse and
// converts its width into a 5-bit distance band code held on SD1..SD5.
// Codes: 0..MAX_BAND distance band, 30 out of range, 31 no echo.
module echo_medidor #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned CYCLES_PER_CM  = 2900,
    parameter int unsigned BAND_CM        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned MAX_BAND       = 29,
    parameter int unsigned HOLDOFF_CYCLES = 3000000
) (
    input  logic           clk,
    input  logic           rst,
    echo_medidor_if.master bus
);
    localparam int unsigned CNT_MAX0 = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > HOLDOFF_CYCLES) ? CNT_MAX0 : HOLDOFF_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);
    localparam int unsigned SUB_W    = $clog2(CYCLES_PER_CM + 1);
    localparam int unsigned CM_W     = $clog2(BAND_CM + 1);
    localparam logic [4:0]  CODE_OOR = 5'd30;
    localparam logic [4:0]  CODE_TMO = 5'd31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_RESULT,
        S_HOLDOFF
    } state_t;

    state_t           r_state;
    logic             r_echo_m;
    logic             r_echo_s;
    logic [CNT_W-1:0] r_cnt;
    logic [SUB_W-1:0] r_sub;
    logic [CM_W-1:0]  r_cm;
    logic [4:0]       r_band;
    logic             r_ovf;
    logic             r_trig;
    logic             r_busy;
    logic             r_valid;
    logic [4:0]       r_sd;

    logic w_cm_done;
    logic w_band_done;
    logic w_timeout;

    assign w_cm_done   = (r_sub == SUB_W'(CYCLES_PER_CM - 1));
    assign w_band_done = w_cm_done && (r_cm == CM_W'(BAND_CM - 1));
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign bus.trig  = r_trig;
    assign bus.busy  = r_busy;
    assign bus.valid = r_valid;
    assign {bus.SD1, bus.SD2, bus.SD3, bus.SD4, bus.SD5} = r_sd;

    // Two-flop synchroniser for the asynchronous echo input
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_echo_m <= 1'b0;
            r_echo_s <= 1'b0;
        end else begin
            r_echo_m <= bus.echo;
            r_echo_s <= r_echo_m;
        end
    end

    // Echo width accumulation: cycles -> cm -> band, freezing once past MAX_BAND.
    // The rising-edge cycle seen in WAIT_ECHO is counted too, so N high cycles give N steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sub  <= '0;
            r_cm   <= '0;
            r_band <= '0;
            r_ovf  <= 1'b0;
        end else if (r_state == S_TRIG) begin
            r_sub  <= '0;
            r_cm   <= '0;
            r_band <= '0;
            r_ovf  <= 1'b0;
        end else if ((r_state == S_WAIT_ECHO || r_state == S_MEASURE) && r_echo_s && !r_ovf) begin
            if (w_band_done) begin
                r_sub <= '0;
                r_cm  <= '0;
                if (r_band == 5'(MAX_BAND)) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_band <= r_band + 5'd1;
                end
            end else if (w_cm_done) begin
                r_sub <= '0;
                r_cm  <= r_cm + CM_W'(1);
            end else begin
                r_sub <= r_sub + SUB_W'(1);
            end
        end
    end

    // Measurement sequencer with registered trig/busy/valid/SD outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_sd    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.enable) begin
                        r_state <= S_TRIG;
                        r_trig  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end
                S_TRIG: begin
                    if (r_cnt == CNT_W'(TRIG_CYCLES - 1)) begin
                        r_state <= S_WAIT_ECHO;
                        r_trig  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_ECHO: begin
                    if (r_echo_s) begin
                        r_state <= S_MEASURE;
                        r_cnt   <= '0;
                    end else if (w_timeout) begin
                        r_state <= S_RESULT;
                        r_sd    <= CODE_TMO;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_MEASURE: begin
                    // r_cnt stays 0 until overflow, then bounds the wait for echo to fall
                    if (!r_echo_s) begin
                        r_state <= S_RESULT;
                        r_sd    <= r_ovf ? CODE_OOR : r_band;
                        r_valid <= 1'b1;
                    end else if (r_ovf) begin
                        if (w_timeout) begin
                            r_state <= S_RESULT;
                            r_sd    <= CODE_OOR;
                            r_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_RESULT: begin
                    r_state <= S_HOLDOFF;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                end
                S_HOLDOFF: begin
                    if (r_cnt == CNT_W'(HOLDOFF_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_trig  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_echo_medidor.sv
// Directed bench for echo_medidor with shortened timing parameters.
module tb_echo_medidor;
    logic clk;
    logic rst;
    logic [4:0] w_sd;
    int n_err;
    int n_chk;

    echo_medidor_if bus ();

    echo_medidor #(
        .TRIG_CYCLES   (10),
        .CYCLES_PER_CM (4),
        .BAND_CM       (2),
        .TIMEOUT_CYCLES(200),
        .MAX_BAND      (29),
        .HOLDOFF_CYCLES(20)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign w_sd = {bus.SD1, bus.SD2, bus.SD3, bus.SD4, bus.SD5};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // From the current sample, wait for trig to rise, then measure its high time.
    // Returns at the first sample with trig low again.
    task automatic wait_trig(output int gap, output int len, output int nvalid, output logic busy_rise);
        gap = 0;
        len = 0;
        nvalid = 0;
        do begin
            @(negedge clk);
            gap++;
            if (bus.valid === 1'b1) nvalid++;
        end while (bus.trig !== 1'b1 && gap < 500);
        busy_rise = bus.busy;
        while (bus.trig === 1'b1 && len < 500) begin
            len++;
            @(negedge clk);
        end
    endtask

    // From a trig-low sample: echo high for n cycles, then wait for valid.
    task automatic meas(input int n, output int vwait);
        repeat (3) @(negedge clk);
        bus.echo = 1'b1;
        repeat (n) @(negedge clk);
        bus.echo = 1'b0;
        vwait = 0;
        do begin
            @(negedge clk);
            vwait++;
        end while (bus.valid !== 1'b1 && vwait < 50);
    endtask

    initial begin
        int gap;
        int len;
        int nv;
        int vw;
        int cnt;
        logic br;

        n_err = 0;
        n_chk = 0;
        rst = 1'b1;
        bus.enable = 1'b0;
        bus.echo = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trig", bus.trig, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_sd", w_sd, 5'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", bus.busy, 1'b0);
        bus.enable = 1'b1;
        wait_trig(gap, len, nv, br);
        chk("first_trig_gap", gap, 1);
        chk("first_busy", br, 1'b1);
        chk("first_trig_len", len, 10);

        // 40 cycles -> 10 cm -> band 5
        meas(40, vw);
        chk("m40_latency", vw, 3);
        chk("m40_sd", w_sd, 5'b00101);
        @(negedge clk);
        chk("m40_valid_width", bus.valid, 1'b0);
        wait_trig(gap, len, nv, br);
        chk("m40_holdoff_gap", gap, 21);
        chk("m40_trig_len", len, 10);

        // 43 cycles -> 10 cm truncated -> band 5
        meas(43, vw);
        chk("m43_sd", w_sd, 5'b00101);
        @(negedge clk);
        wait_trig(gap, len, nv, br);
        chk("m43_holdoff_gap", gap, 21);

        // 7 cycles -> 1 cm -> band 0
        meas(7, vw);
        chk("m7_valid", bus.valid, 1'b1);
        chk("m7_sd", w_sd, 5'b00000);
        @(negedge clk);
        wait_trig(gap, len, nv, br);

        // no echo -> code 31 after 200 wait cycles
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.valid !== 1'b1 && cnt < 400);
        chk("noecho_wait", cnt, 200);
        chk("noecho_sd", w_sd, 5'b11111);
        @(negedge clk);
        wait_trig(gap, len, nv, br);
        chk("noecho_holdoff_gap", gap, 21);

        // 300 cycles -> 75 cm -> band 37 > 29 -> code 30
        meas(300, vw);
        chk("m300_latency", vw, 3);
        chk("m300_sd", w_sd, 5'b11110);
        @(negedge clk);
        chk("m300_valid_width", bus.valid, 1'b0);
        // echo during HOLDOFF must not produce a result nor shift the schedule
        bus.echo = 1'b1;
        repeat (5) @(negedge clk);
        bus.echo = 1'b0;
        wait_trig(gap, len, nv, br);
        chk("holdoff_echo_gap", gap, 16);
        chk("holdoff_echo_nvalid", nv, 0);
        meas(40, vw);
        chk("after_holdoff_sd", w_sd, 5'b00101);
        @(negedge clk);
        wait_trig(gap, len, nv, br);

        // echo never falls: overflow at 240 steps, then 200-cycle bound -> code 30
        bus.echo = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.valid !== 1'b1 && cnt < 700);
        chk("stuck_echo_wait", cnt, 442);
        chk("stuck_echo_sd", w_sd, 5'b11110);
        bus.echo = 1'b0;
        @(negedge clk);
        wait_trig(gap, len, nv, br);
        chk("stuck_holdoff_gap", gap, 21);
        chk("stuck_nvalid", nv, 0);

        // async reset in the middle of MEASURE
        bus.echo = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstm_trig", bus.trig, 1'b0);
        chk("rstm_busy", bus.busy, 1'b0);
        chk("rstm_valid", bus.valid, 1'b0);
        chk("rstm_sd", w_sd, 5'd0);
        bus.echo = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // async reset while trig is high drops it immediately
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (bus.trig !== 1'b1 && cnt < 50);
        repeat (3) @(negedge clk);
        chk("rstt_trig_before", bus.trig, 1'b1);
        rst = 1'b1;
        #1;
        chk("rstt_trig", bus.trig, 1'b0);
        chk("rstt_busy", bus.busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_trig(gap, len, nv, br);
        chk("rstt_restart_gap", gap, 1);
        chk("rstt_restart_len", len, 10);

        // enable dropped at RESULT -> one result, then stays IDLE
        meas(40, vw);
        bus.enable = 1'b0;
        chk("en0_sd", w_sd, 5'b00101);
        cnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.trig === 1'b1) cnt++;
        end
        chk("en0_no_trig", cnt, 0);
        chk("en0_busy", bus.busy, 1'b0);
        chk("en0_sd_held", w_sd, 5'b00101);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
